// File: rtl/fpga_regs_readback_if.sv
// Bus bundle for fpga_regs_readback.
//   master_data    : request byte from the master (bit 7 marks a real request)
//   valid_bus      : per-channel one-cycle request strobe
//   reg_bus        : per-channel live register value, byte i on [8i+7:8i]
//   rdreq_bus      : per-channel one-cycle pop strobe
//   have_msg_bus   : per-channel "unread bytes present"
//   slave_data_bus : per-channel show-ahead head byte
//   len_bus        : per-channel bytes remaining (0..2), byte i on [8i+7:8i]
// The master modport is the requester/reader side; the slave modport is the block.
interface fpga_regs_readback_if #(
  parameter int unsigned NCH = 10
);
  logic [7:0]       master_data;
  logic [NCH-1:0]   valid_bus;
  logic [NCH*8-1:0] reg_bus;
  logic [NCH-1:0]   rdreq_bus;
  logic [NCH-1:0]   have_msg_bus;
  logic [NCH*8-1:0] slave_data_bus;
  logic [NCH*8-1:0] len_bus;

  modport master (
    output master_data, valid_bus, reg_bus, rdreq_bus,
    input  have_msg_bus, slave_data_bus, len_bus
  );

  modport slave (
    input  master_data, valid_bus, reg_bus, rdreq_bus,
    output have_msg_bus, slave_data_bus, len_bus
  );
endinterface

// File: rtl/fpga_regs_readback.sv
// Per-channel register readback. A request on channel i snapshots that channel's
// register and queues a two-byte message {header, value}; the reader pops it one
// byte at a time. A request arriving while a message is still pending is dropped
// and flagged in the header of the next accepted message.
//
// Ports:
//   clk : single clock, rising edge
//   rst : synchronous active-high reset, clears all channel state
//   bus : fpga_regs_readback_if slave modport (requests, pops, head bytes, lengths)
//
// Parameters:
//   NCH   : number of channels
//   TMO_W : unread-message timeout counter width
//
// Optional feature: define READBACK_TIMEOUT_EN to add a per-channel timeout that
// discards a message left unread until its counter reaches all-ones.
module fpga_regs_readback #(
  parameter int unsigned NCH   = 10,
  parameter int unsigned TMO_W = 16
) (
  input logic                    clk,
  input logic                    rst,
  fpga_regs_readback_if.slave    bus
);

  logic [NCH-1:0]   have_msg;
  logic [NCH*8-1:0] slave_data;
  logic [NCH*8-1:0] len_flat;

  // Only bit 7 of master_data qualifies a request; the rest is don't-care.
  logic unused_data;
  assign unused_data = ^bus.master_data[6:0];

`ifndef READBACK_TIMEOUT_EN
  logic [TMO_W-1:0] unused_tmo;
  assign unused_tmo = '0;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam logic [3:0] ChId = 4'(i);

    logic [1:0] len_q, len_d;
    logic [7:0] hdr_q, hdr_d;
    logic [7:0] val_q, val_d;
    logic       ovf_q, ovf_d;
    logic       req;
    logic       pop;
    logic [7:0] head;

    assign req = bus.valid_bus[i] & bus.master_data[7];
    assign pop = bus.rdreq_bus[i] & (len_q != 2'd0);

`ifdef READBACK_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    always_comb begin
      len_d = len_q;
      hdr_d = hdr_q;
      val_d = val_q;
      ovf_d = ovf_q;
      if (len_q == 2'd0) begin
        if (req) begin
          val_d = bus.reg_bus[8*i +: 8];
          hdr_d = {1'b1, ovf_q, 2'b00, ChId};
          len_d = 2'd2;
          ovf_d = 1'b0;
        end
      end else begin
        // A busy channel drops the request but still honours a same-cycle pop.
        if (req) ovf_d = 1'b1;
        if (pop) len_d = len_q - 2'd1;
      end
`ifdef READBACK_TIMEOUT_EN
      tmo_d = tmo_q;
      if (len_q != 2'd0) begin
        if (&tmo_q) begin
          len_d = 2'd0;
          ovf_d = 1'b1;
          tmo_d = '0;
        end else if (pop) begin
          tmo_d = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
`endif
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        len_q <= 2'd0;
        hdr_q <= 8'h00;
        val_q <= 8'h00;
        ovf_q <= 1'b0;
`ifdef READBACK_TIMEOUT_EN
        tmo_q <= '0;
`endif
      end else begin
        len_q <= len_d;
        hdr_q <= hdr_d;
        val_q <= val_d;
        ovf_q <= ovf_d;
`ifdef READBACK_TIMEOUT_EN
        tmo_q <= tmo_d;
`endif
      end
    end

    // Show-ahead head byte selected by how many bytes remain.
    always_comb begin
      head = 8'h00;
      case (len_q)
        2'd2:    head = hdr_q;
        2'd1:    head = val_q;
        default: head = 8'h00;
      endcase
    end

    assign have_msg[i]          = (len_q != 2'd0);
    assign slave_data[8*i +: 8] = head;
    assign len_flat[8*i +: 8]   = {6'b000000, len_q};
  end

  assign bus.have_msg_bus   = have_msg;
  assign bus.slave_data_bus = slave_data;
  assign bus.len_bus        = len_flat;

endmodule

// File: tb/tb_fpga_regs_readback.sv
module tb_fpga_regs_readback;

  localparam int NCH = 10;
`ifdef READBACK_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 16;
`endif
  localparam int MAX_AGE = (1 << TMO) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpga_regs_readback_if #(.NCH(NCH)) bus_if ();

  fpga_regs_readback #(.NCH(NCH), .TMO_W(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: each channel is a byte queue of the unread message.
  logic [7:0] mq [NCH][$];
  logic       m_ovf [NCH];
  int         m_age [NCH];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NCH; i++) begin
      logic req;
      req = bus_if.valid_bus[i] && bus_if.master_data[7];
      if (rst) begin
        mq[i].delete();
        m_ovf[i] = 1'b0;
        m_age[i] = 0;
      end else if (mq[i].size() == 0) begin
        if (req) begin
          mq[i].push_back({1'b1, m_ovf[i], 2'b00, 4'(i)});
          mq[i].push_back(bus_if.reg_bus[8*i +: 8]);
          m_ovf[i] = 1'b0;
          m_age[i] = 0;
        end
      end else begin
`ifdef READBACK_TIMEOUT_EN
        if (m_age[i] == MAX_AGE) begin
          mq[i].delete();
          m_ovf[i] = 1'b1;
          m_age[i] = 0;
          continue;
        end
`endif
        if (req) m_ovf[i] = 1'b1;
        if (bus_if.rdreq_bus[i]) begin
          void'(mq[i].pop_front());
          m_age[i] = 0;
        end else begin
          m_age[i] = m_age[i] + 1;
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [79:0] eh, ed, el;
    eh = '0;
    ed = '0;
    el = '0;
    for (int i = 0; i < NCH; i++) begin
      eh[i]         = (mq[i].size() != 0);
      ed[8*i +: 8]  = (mq[i].size() != 0) ? mq[i][0] : 8'h00;
      el[8*i +: 8]  = 8'(mq[i].size());
    end
    chk({tag, "_have"}, 80'(bus_if.have_msg_bus), eh);
    chk({tag, "_data"}, bus_if.slave_data_bus, ed);
    chk({tag, "_len"}, bus_if.len_bus, el);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
    bus_if.valid_bus   = '0;
    bus_if.rdreq_bus   = '0;
    bus_if.master_data = 8'h00;
    rst                = 1'b0;
  endtask

  task automatic req(input int ch, input logic [7:0] md);
    bus_if.valid_bus     = '0;
    bus_if.valid_bus[ch] = 1'b1;
    bus_if.master_data   = md;
  endtask

  task automatic pop(input int ch);
    bus_if.rdreq_bus[ch] = 1'b1;
  endtask

  // Single-channel view for spec-level checks.
  task automatic chk_ch(input string name, input int ch, input logic e_have,
                        input logic [7:0] e_data, input logic [7:0] e_len);
    chk({name, "_have"}, 80'(bus_if.have_msg_bus[ch]), 80'(e_have));
    chk({name, "_data"}, 80'(bus_if.slave_data_bus[8*ch +: 8]), 80'(e_data));
    chk({name, "_len"}, 80'(bus_if.len_bus[8*ch +: 8]), 80'(e_len));
  endtask

  typedef struct {
    logic [9:0]  vb;
    logic [7:0]  md;
    logic [9:0]  rd;
    logic [79:0] rb;
    int          ch;
    logic        e_have;
    logic [7:0]  e_data;
    logic [7:0]  e_len;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{10'h008, 8'h80, 10'h000, 80'h5C << 24, 3, 1'b1, 8'h83, 8'd2};
    vecs[1] = '{10'h000, 8'h00, 10'h008, 80'h0,        3, 1'b1, 8'h5C, 8'd1};
    vecs[2] = '{10'h000, 8'h00, 10'h008, 80'h0,        3, 1'b0, 8'h00, 8'd0};
    vecs[3] = '{10'h001, 8'h7F, 10'h000, 80'hAB,       0, 1'b0, 8'h00, 8'd0};
    vecs[4] = '{10'h000, 8'h00, 10'h001, 80'h0,        0, 1'b0, 8'h00, 8'd0};

    for (int i = 0; i < NCH; i++) begin
      m_ovf[i] = 1'b0;
      m_age[i] = 0;
    end
    bus_if.master_data = 8'h00;
    bus_if.valid_bus   = '0;
    bus_if.rdreq_bus   = '0;
    bus_if.reg_bus     = '0;

    // Reset state.
    rst = 1'b1;
    tick("reset");
    chk("reset_have_all", 80'(bus_if.have_msg_bus), 80'h0);
    chk("reset_len_all", bus_if.len_bus, 80'h0);

    // Basic read and ignored request/pop, table-driven.
    for (int v = 0; v < 5; v++) begin
      bus_if.valid_bus   = vecs[v].vb;
      bus_if.master_data = vecs[v].md;
      bus_if.rdreq_bus   = vecs[v].rd;
      bus_if.reg_bus     = vecs[v].rb;
      tick($sformatf("vec%0d", v));
      chk_ch($sformatf("vec%0d_ch", v), vecs[v].ch, vecs[v].e_have, vecs[v].e_data,
             vecs[v].e_len);
    end

    // Snapshot: reg changes after accept do not alter the value byte.
    bus_if.reg_bus = 80'h11 << 8;
    req(1, 8'h80);
    tick("snap_req");
    bus_if.reg_bus = 80'h99 << 8;
    pop(1);
    tick("snap_pop");
    chk_ch("snap_val", 1, 1'b1, 8'h11, 8'd1);
    pop(1);
    tick("snap_pop2");

    // Overflow on ch0.
    req(0, 8'h80);
    tick("ovf_req1");
    req(0, 8'h80);
    tick("ovf_req2");
    pop(0);
    tick("ovf_pop1");
    pop(0);
    tick("ovf_pop2");
    req(0, 8'h80);
    tick("ovf_req3");
    chk_ch("ovf_hdr", 0, 1'b1, 8'hC0, 8'd2);
    pop(0);
    tick("ovf_pop3");
    pop(0);
    tick("ovf_pop4");
    req(0, 8'h80);
    tick("ovf_req4");
    chk_ch("ovf_cleared", 0, 1'b1, 8'h80, 8'd2);
    pop(0);
    tick("ovf_pop5");
    pop(0);
    tick("ovf_pop6");

    // Same-cycle pop and request on ch9.
    req(9, 8'h80);
    tick("sc_req");
    pop(9);
    tick("sc_pop");
    chk_ch("sc_len1", 9, 1'b1, 8'h00, 8'd1);
    req(9, 8'hFF);
    pop(9);
    tick("sc_both");
    chk_ch("sc_len0", 9, 1'b0, 8'h00, 8'd0);
    req(9, 8'h80);
    tick("sc_req2");
    chk_ch("sc_hdr", 9, 1'b1, 8'hC9, 8'd2);
    pop(9);
    tick("sc_pop2");
    pop(9);
    tick("sc_pop3");

    // Reset mid-message on ch5.
    req(5, 8'h80);
    tick("rm_req");
    pop(5);
    tick("rm_pop");
    rst = 1'b1;
    tick("rm_rst");
    chk("rm_len_all", bus_if.len_bus, 80'h0);
    chk("rm_have_all", 80'(bus_if.have_msg_bus), 80'h0);
    req(5, 8'h80);
    tick("rm_req2");
    chk_ch("rm_hdr", 5, 1'b1, 8'h85, 8'd2);
    pop(5);
    tick("rm_pop2");
    pop(5);
    tick("rm_pop3");

`ifdef READBACK_TIMEOUT_EN
    // Unread message times out; next header carries the overflow bit.
    req(2, 8'h80);
    tick("to_req");
    for (int k = 0; k < 15; k++) tick("to_wait");
    chk_ch("to_held", 2, 1'b1, 8'h82, 8'd2);
    begin
      int budget;
      budget = 0;
      while (bus_if.len_bus[8*2 +: 8] != 8'd0 && budget < 4) begin
        tick("to_drain");
        budget++;
      end
      chk("to_dropped", 80'(bus_if.len_bus[8*2 +: 8]), 80'h0);
    end
    req(2, 8'h80);
    tick("to_req2");
    chk("to_hdr_bit6", 80'(bus_if.slave_data_bus[8*2 + 6]), 80'h1);
    pop(2);
    tick("to_pop1");
    pop(2);
    tick("to_pop2");
`else
    // Without the timeout a message is held indefinitely.
    req(2, 8'h80);
    tick("hold_req");
    for (int k = 0; k < 40; k++) tick("hold_wait");
    chk_ch("hold_kept", 2, 1'b1, 8'h82, 8'd2);
    pop(2);
    tick("hold_pop1");
    pop(2);
    tick("hold_pop2");
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      bus_if.valid_bus   = 10'($urandom & $urandom);
      bus_if.master_data = 8'($urandom_range(0, 255));
      bus_if.rdreq_bus   = 10'($urandom);
      bus_if.reg_bus     = 80'({$urandom, $urandom, $urandom});
      rst                = ($urandom_range(0, 63) == 0);
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpga_regs_readback.md
FPGA_REGS_READBACK -- requirements
Module: fpga_regs_readback

Interface
REQ-001 SHALL have parameter NCH, default 10: number of message channels; channel index i in 0..NCH-1.
REQ-002 SHALL have parameter TMO_W, default 16: timeout counter width in bits; used only with READBACK_TIMEOUT_EN.
REQ-003 SHALL have port clk  input  1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port master_data  input  8: request byte from the master.
REQ-006 SHALL have port valid_bus  input  NCH: one-cycle strobe; bit i marks master_data as a request to channel i.
REQ-007 SHALL have port reg_bus  input  NCH*8: current register value of channel i, carried on bits [8i+7:8i].
REQ-008 SHALL have port rdreq_bus  input  NCH: one-cycle pop strobe per channel.
REQ-009 SHALL have port have_msg_bus  output  NCH: bit i high while channel i holds unread bytes.
REQ-010 SHALL have port slave_data_bus  output  NCH*8: head byte of channel i (show-ahead).
REQ-011 SHALL have port len_bus  output  NCH*8: bytes remaining in channel i, range 0..2.

Function
REQ-012 SHALL keep each channel independent: state {len, hdr, val, ovf} per channel, with no cross-channel arbitration.
REQ-013 SHALL treat a request on channel i as valid_bus[i]=1 and master_data[7]=1.
- Requests with master_data[7]=0 are ignored and change no state.
REQ-014 SHALL accept a request only when len_i==0 in that cycle.
- On accept: val_i <= reg_bus byte i sampled that cycle.
- On accept: hdr_i <= {1'b1, ovf_i, 2'b00, i[3:0]}.
- On accept: len_i <= 2 and ovf_i <= 0.
REQ-015 SHALL drop a request arriving while len_i!=0 and set ovf_i=1.
- This applies even if rdreq_bus[i] is asserted in the same cycle.
REQ-016 SHALL make slave_data byte i combinational on len_i:
- len_i=2 -> hdr_i;
- len_i=1 -> val_i;
- len_i=0 -> 8'h00.
REQ-017 SHALL, on rdreq_bus[i] with len_i!=0, decrement len_i by 1 at the next edge; the new head byte is visible the following cycle.
REQ-018 SHALL ignore rdreq_bus[i] while len_i==0: no underflow, no state change.
REQ-019 SHALL drive have_msg_bus[i] = (len_i!=0), combinationally.
REQ-020 SHALL take 1 cycle from an accepted request to have_msg_bus[i]=1 and len_i=2.
REQ-021 SHALL capture the register snapshot at request time; later reg_bus changes do not alter val_i.
REQ-022 SHALL let the same-cycle request and pop from REQ-015 complete the pop: len_i 1->0, ovf_i=1.
- The next request then accepts normally, with the header ovf bit set.

Reset
REQ-023 SHALL, while rst=1 at a clk edge, clear every len_i, hdr_i, val_i and ovf_i to 0.
- Outputs then read have_msg_bus=0, slave_data_bus=0, len_bus=0.
REQ-024 SHALL discard any partially read message when rst asserts mid-message; no header or value byte survives.

Configuration
REQ-025 SHALL compile the timeout feature in only when macro READBACK_TIMEOUT_EN is defined.
REQ-026 SHALL, with READBACK_TIMEOUT_EN defined, keep a TMO_W-bit counter per channel:
- it clears on accept and on each valid pop;
- it increments each cycle while len_i!=0;
- at all-ones it forces len_i <= 0 and ovf_i <= 1, and clears itself.
REQ-027 SHALL, without READBACK_TIMEOUT_EN, hold a message until it is fully popped or rst asserts; no counter logic is present.

Verification
REQ-028 SHALL cover a basic read:
- stimulus: reg byte 3 = 8'h5C; valid_bus=10'h008; master_data=8'h80;
- next cycle: have_msg[3]=1, len=2, data=8'h83;
- after rdreq: len=1, data=8'h5C;
- after rdreq: have_msg[3]=0, data=8'h00.
REQ-029 SHALL cover overflow:
- stimulus: two requests on ch0 with no pop between; pop both bytes; request again;
- response: second header = 8'hC0, ovf cleared afterwards.
REQ-030 SHALL cover ignored requests and pops:
- master_data=8'h7F with valid_bus=10'h001 -> no message;
- rdreq on an empty channel -> len stays 0.
REQ-031 SHALL cover the same-cycle pop and request:
- ch9 at len=1; rdreq[9] and valid[9] (8'hFF) in one cycle;
- response: len=0, then the next request header = 8'hC9.
REQ-032 SHALL cover reset mid-message:
- rst pulsed while ch5 len=1;
- response: len_bus=0, have_msg_bus=0, next header = 8'h85.
REQ-033 SHALL cover timeout, with READBACK_TIMEOUT_EN and TMO_W=4:
- message left unread for 15 cycles;
- response: len drops to 0, next header has bit6=1.
